// File: rtl/loader_response_tx.sv
// Turns loader completion events into UART response messages (tag byte plus
// optional little-endian address bytes), buffered in a small FIFO.
module loader_response_tx #(
    parameter int BITWIDTH    = 16,
    parameter int QUEUE_DEPTH = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                resp_valid,
    output logic                resp_ready,
    input  logic [1:0]          resp_kind,
    input  logic [5:0]          resp_status,
    input  logic [BITWIDTH-1:0] resp_addr,
    output logic                write_lock_req,
    input  logic                write_lock_res,
    input  logic                write_ready,
    output logic [7:0]          data_in,
    output logic                data_in_valid,
    output logic                busy
);

    localparam int ADDR_BYTES = BITWIDTH / 8;
    localparam int PTR_W      = $clog2(QUEUE_DEPTH);
    localparam int CNT_W      = $clog2(QUEUE_DEPTH + 1);
    localparam int IDX_W      = (ADDR_BYTES > 1) ? $clog2(ADDR_BYTES) : 1;

    localparam logic [1:0] KIND_IMEM = 2'b01;
    localparam logic [1:0] KIND_BMEM = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        LOCK,
        SEND_TAG,
        SEND_ADDR,
        RELEASE
    } state_t;

    logic [1:0]          q_kind   [QUEUE_DEPTH];
    logic [5:0]          q_status [QUEUE_DEPTH];
    logic [BITWIDTH-1:0] q_addr   [QUEUE_DEPTH];

    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [CNT_W-1:0]    count;

    state_t              state;
    logic                send_q;
    logic [IDX_W-1:0]    byte_idx;
    logic [1:0]          head_kind;
    logic [BITWIDTH-1:0] head_addr;

    logic full;
    logic push;
    logic pop;
    logic accept;
    logic head_has_addr;
    logic last_byte;

    function automatic logic [7:0] addr_byte(input logic [BITWIDTH-1:0] addr,
                                             input logic [IDX_W-1:0]    idx);
        return addr[8*idx +: 8];
    endfunction

    assign full          = (count == CNT_W'(QUEUE_DEPTH));
    assign resp_ready    = reset & ~full;
    assign push          = resp_valid & resp_ready;
    assign data_in_valid = send_q & write_lock_res;
    assign accept        = data_in_valid & write_ready;
    assign head_has_addr = (head_kind == KIND_IMEM) | (head_kind == KIND_BMEM);
    assign last_byte     = (byte_idx == IDX_W'(ADDR_BYTES - 1));
    // The head entry leaves the queue only once its final byte is accepted.
    assign pop           = accept & (((state == SEND_TAG) & ~head_has_addr) |
                                     ((state == SEND_ADDR) & last_byte));
    assign busy          = (count != '0) | (state != IDLE);

    always_ff @(posedge clock) begin
        if (push) begin
            q_kind[wr_ptr]   <= resp_kind;
            q_status[wr_ptr] <= resp_status;
            q_addr[wr_ptr]   <= resp_addr;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state          <= IDLE;
            write_lock_req <= 1'b0;
            send_q         <= 1'b0;
            data_in        <= '0;
            byte_idx       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (count != '0) begin
                        state          <= LOCK;
                        write_lock_req <= 1'b1;
                    end
                end
                LOCK: begin
                    // Snapshot the head so later pushes cannot disturb this message.
                    if (write_lock_res) begin
                        head_kind <= q_kind[rd_ptr];
                        head_addr <= q_addr[rd_ptr];
                        data_in   <= {q_kind[rd_ptr], q_status[rd_ptr]};
                        send_q    <= 1'b1;
                        state     <= SEND_TAG;
                    end
                end
                SEND_TAG: begin
                    if (accept) begin
                        if (head_has_addr) begin
                            data_in  <= addr_byte(head_addr, '0);
                            byte_idx <= '0;
                            state    <= SEND_ADDR;
                        end else begin
                            send_q         <= 1'b0;
                            write_lock_req <= 1'b0;
                            state          <= RELEASE;
                        end
                    end
                end
                SEND_ADDR: begin
                    if (accept) begin
                        if (last_byte) begin
                            send_q         <= 1'b0;
                            write_lock_req <= 1'b0;
                            state          <= RELEASE;
                        end else begin
                            data_in  <= addr_byte(head_addr, byte_idx + IDX_W'(1));
                            byte_idx <= byte_idx + IDX_W'(1);
                        end
                    end
                end
                RELEASE: begin
                    state <= IDLE;
                end
                default: begin
                    state          <= IDLE;
                    write_lock_req <= 1'b0;
                    send_q         <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_loader_response_tx.sv
// Directed bench for loader_response_tx: stimulus queues hand-computed bytes,
// a negedge monitor pops and compares every byte the DUT hands to the UART.
module tb_loader_response_tx;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        resp_valid = 1'b0;
    logic        resp_ready;
    logic [1:0]  resp_kind = 2'b00;
    logic [5:0]  resp_status = 6'h00;
    logic [15:0] resp_addr = 16'h0000;
    logic        write_lock_req;
    logic        write_lock_res = 1'b0;
    logic        write_ready = 1'b0;
    logic [7:0]  data_in;
    logic        data_in_valid;
    logic        busy;

    typedef struct packed {
        logic [7:0] b;
        logic       first;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    logic released = 1'b1;

    always #5 clock = ~clock;

    loader_response_tx #(.BITWIDTH(16), .QUEUE_DEPTH(4)) dut (
        .clock          (clock),
        .reset          (reset),
        .resp_valid     (resp_valid),
        .resp_ready     (resp_ready),
        .resp_kind      (resp_kind),
        .resp_status    (resp_status),
        .resp_addr      (resp_addr),
        .write_lock_req (write_lock_req),
        .write_lock_res (write_lock_res),
        .write_ready    (write_ready),
        .data_in        (data_in),
        .data_in_valid  (data_in_valid),
        .busy           (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out waiting on the DUT", name);
    endtask

    // Monitor: a byte is taken at the next rising edge when valid & ready hold here.
    always @(negedge clock) begin : monitor
        exp_t e;
        if (reset && data_in_valid && write_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_byte: got 0x%0h expected no byte", data_in);
            end else begin
                e = exp_q.pop_front();
                check("tx_byte", 32'(data_in), 32'(e.b));
                check("lock_held", 32'(write_lock_req), 32'd1);
                if (e.first) begin
                    check("release_before_msg", 32'(released), 32'd1);
                    released = 1'b0;
                end
            end
        end
        if (!write_lock_req) released = 1'b1;
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic expect_msg(input int n, input logic [7:0] b0, input logic [7:0] b1,
                              input logic [7:0] b2);
        exp_t e;
        e.b = b0; e.first = 1'b1; exp_q.push_back(e);
        if (n > 1) begin e.b = b1; e.first = 1'b0; exp_q.push_back(e); end
        if (n > 2) begin e.b = b2; e.first = 1'b0; exp_q.push_back(e); end
    endtask

    task automatic push_evt(input logic [1:0] k, input logic [5:0] st, input logic [15:0] a,
                            input int n, input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2);
        int t = 0;
        bit done = 1'b0;
        expect_msg(n, b0, b1, b2);
        resp_kind   = k;
        resp_status = st;
        resp_addr   = a;
        resp_valid  = 1'b1;
        while (!done && t < 64) begin
            @(negedge clock);
            if (resp_ready) done = 1'b1;
            else t++;
        end
        step();
        resp_valid = 1'b0;
        if (!done) fail_now("push_accept");
    endtask

    task automatic wait_valid(input string name);
        int t = 0;
        bit seen = 1'b0;
        while (!seen && t < 64) begin
            @(negedge clock);
            if (data_in_valid) seen = 1'b1;
            else t++;
        end
        if (!seen) fail_now(name);
    endtask

    task automatic wait_idle(input string name);
        int t = 0;
        bit idle = 1'b0;
        while (!idle && t < 200) begin
            @(negedge clock);
            if (!busy) idle = 1'b1;
            else t++;
        end
        if (!idle) fail_now(name);
        check({name, "_drained"}, 32'(exp_q.size()), 32'd0);
        check({name, "_lock_low"}, 32'(write_lock_req), 32'd0);
        step();
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : stimulus
        int t;
        bit seen;
        bit pat[5];
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

        // Reset state
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("rst_lock_req", 32'(write_lock_req), 32'd0);
        check("rst_data_in", 32'(data_in), 32'd0);
        check("rst_valid", 32'(data_in_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ready", 32'(resp_ready), 32'd0);
        step();
        reset = 1'b1;
        @(negedge clock);
        check("post_rst_ready", 32'(resp_ready), 32'd1);
        step();

        // Single ALIVE
        write_lock_res = 1'b1;
        write_ready    = 1'b1;
        push_evt(2'b00, 6'h15, 16'h0000, 1, 8'h15, 8'h00, 8'h00);
        t = 0; seen = 1'b0;
        while (!seen && t < 16) begin
            @(negedge clock);
            if (write_lock_req) seen = 1'b1;
            else t++;
        end
        check("t1_lock_rise", 32'(seen), 32'd1);
        wait_idle("t1");

        // IMEM, three bytes back to back
        push_evt(2'b01, 6'h01, 16'hBEEF, 3, 8'h41, 8'hEF, 8'hBE);
        wait_valid("t2_first");
        @(negedge clock);
        check("t2_consec1", 32'(data_in_valid), 32'd1);
        @(negedge clock);
        check("t2_consec2", 32'(data_in_valid), 32'd1);
        wait_idle("t2");

        // Queue full while the grant is withheld
        write_lock_res = 1'b0;
        for (int i = 0; i < 4; i++)
            push_evt(2'b10, 6'h00, 16'(i), 3, 8'h80, 8'(i), 8'h00);
        @(negedge clock);
        check("t3_full", 32'(resp_ready), 32'd0);
        step();
        expect_msg(3, 8'h80, 8'h04, 8'h00);
        resp_kind = 2'b10; resp_status = 6'h00; resp_addr = 16'h0004; resp_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("t3_held", 32'(resp_ready), 32'd0);
            check("t3_no_grant_valid", 32'(data_in_valid), 32'd0);
            step();
        end
        write_lock_res = 1'b1;
        t = 0; seen = 1'b0;
        while (!seen && t < 64) begin
            @(negedge clock);
            if (resp_ready) seen = 1'b1;
            else t++;
        end
        step();
        resp_valid = 1'b0;
        if (!seen) fail_now("t3_fifth_accept");
        wait_idle("t3");

        // Back-pressure on write_ready
        write_ready = 1'b0;
        push_evt(2'b01, 6'h00, 16'h1234, 3, 8'h40, 8'h34, 8'h12);
        wait_valid("t4_first");
        step();
        for (int i = 0; i < 5; i++) begin
            write_ready = pat[i];
            @(negedge clock);
            if (!pat[i]) begin
                check("t4_hold_data", 32'(data_in), 32'h34);
                check("t4_hold_valid", 32'(data_in_valid), 32'd1);
            end
            step();
        end
        write_ready = 1'b1;
        wait_idle("t4");

        // Grant dropped for three cycles after the tag
        push_evt(2'b10, 6'h03, 16'hA55A, 3, 8'h83, 8'h5A, 8'hA5);
        wait_valid("t5_first");
        step();
        write_lock_res = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("t5_gap_valid", 32'(data_in_valid), 32'd0);
            check("t5_gap_lock", 32'(write_lock_req), 32'd1);
            check("t5_gap_data", 32'(data_in), 32'h5A);
            step();
        end
        write_lock_res = 1'b1;
        wait_idle("t5");

        // Reset in the middle of a message with two more queued
        write_lock_res = 1'b0;
        push_evt(2'b01, 6'h05, 16'h1111, 3, 8'h45, 8'h11, 8'h11);
        push_evt(2'b00, 6'h01, 16'h0000, 1, 8'h01, 8'h00, 8'h00);
        push_evt(2'b11, 6'h02, 16'h0000, 1, 8'hC2, 8'h00, 8'h00);
        write_lock_res = 1'b1;
        wait_valid("t6_first");
        step();
        reset = 1'b0;
        exp_q.delete();
        step();
        @(negedge clock);
        check("t6_lock_req", 32'(write_lock_req), 32'd0);
        check("t6_valid", 32'(data_in_valid), 32'd0);
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_ready", 32'(resp_ready), 32'd0);
        check("t6_data_in", 32'(data_in), 32'd0);
        step();
        reset = 1'b1;
        @(negedge clock);
        check("t6_ready_after", 32'(resp_ready), 32'd1);
        repeat (10) @(negedge clock);
        check("t6_idle_after", 32'(busy), 32'd0);
        check("t6_lock_after", 32'(write_lock_req), 32'd0);

        check("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
